// File: rtl/pair_unit_arbiter.sv
// Round-robin arbiter that shares one 8-bit pair-combine unit among N_REQ requesters.
// One operand pair is in flight at a time; each result or timeout is returned tagged with its requester.
module pair_unit_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_a_i,
    input  logic [8*N_REQ-1:0]   req_b_i,
    output logic [N_REQ-1:0]     req_ready_o,

    output logic                 unit_a_valid_o,
    output logic                 unit_b_valid_o,
    output logic [7:0]           unit_a_o,
    output logic [7:0]           unit_b_o,
    input  logic [15:0]          unit_result_i,
    input  logic                 unit_result_valid_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [15:0]          rsp_data_o,
    output logic                 rsp_error_o
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    localparam logic [ID_W:0]   NReqW   = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LastId  = ID_W'(N_REQ - 1);
    localparam logic [7:0]      CntLast = 8'(TIMEOUT - 1);

    state_e          state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] win_q;
    logic [7:0]      op_a_q;
    logic [7:0]      op_b_q;
    logic [7:0]      cnt_q;
    logic            unit_valid_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_error_q;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic [ID_W:0]    cand_sum;
    logic [ID_W-1:0]  cand_id;
    logic [7:0]       sel_a;
    logic [7:0]       sel_b;
    logic [ID_W-1:0]  ptr_next;

    // Search from ptr upward, wrapping at N_REQ; the first valid requester wins.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        cand_sum    = '0;
        cand_id     = '0;
        if (state_q == StIdle && !reset) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cand_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
                cand_id  = (cand_sum >= NReqW) ? ID_W'(cand_sum - NReqW) : ID_W'(cand_sum);
                if (!grant_found && req_valid_i[cand_id]) begin
                    grant_found    = 1'b1;
                    grant_id       = cand_id;
                    grant[cand_id] = 1'b1;
                end
            end
        end
    end

    assign sel_a    = req_a_i[8*grant_id +: 8];
    assign sel_b    = req_b_i[8*grant_id +: 8];
    assign ptr_next = (win_q == LastId) ? '0 : win_q + ID_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            win_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cnt_q        <= '0;
            unit_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        win_q        <= grant_id;
                        op_a_q       <= sel_a;
                        op_b_q       <= sel_b;
                        unit_valid_q <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    unit_valid_q <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A result landing on the timeout cycle still counts as a success.
                    if (unit_result_valid_i) begin
                        rsp_data_q  <= unit_result_i;
                        rsp_error_q <= 1'b0;
                        rsp_id_q    <= win_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (cnt_q == CntLast) begin
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b1;
                        rsp_id_q    <= win_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_next;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o    = grant;
    assign unit_a_valid_o = unit_valid_q;
    assign unit_b_valid_o = unit_valid_q;
    assign unit_a_o       = op_a_q;
    assign unit_b_o       = op_b_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_id_o       = rsp_id_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_error_o    = rsp_error_q;

endmodule

// File: tb/tb_pair_unit_arbiter.sv
// Scoreboard bench for pair_unit_arbiter: a behavioural combine unit with programmable latency,
// a round-robin reference model and an expected-response queue checked on every response.
module tb_pair_unit_arbiter;

    localparam int TO = 15;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        unit_a_valid;
    logic        unit_b_valid;
    logic [7:0]  unit_a;
    logic [7:0]  unit_b;
    logic [15:0] unit_result = '0;
    logic        unit_result_valid = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_error;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int          unit_lat = 3;
    int          stray_req = 0;
    int          stray_done = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_data = '0;

    exp_t        sb_q[$];
    exp_t        cur;
    bit          cur_ok = 1'b0;
    bit          in_rsp = 1'b0;
    bit          m_busy = 1'b0;
    int          m_ptr = 0;
    int          last_acc_cyc = -10;
    logic [7:0]  last_a = '0;
    logic [7:0]  last_b = '0;
    int          n_acc = 0;
    int          n_rsp = 0;
    int          hs_cyc = 0;
    int          acc_id_q[$];
    int          acc_cyc_q[$];

    pair_unit_arbiter #(
        .N_REQ  (4),
        .TIMEOUT(TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (req_valid),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .req_ready_o        (req_ready),
        .unit_a_valid_o     (unit_a_valid),
        .unit_b_valid_o     (unit_b_valid),
        .unit_a_o           (unit_a),
        .unit_b_o           (unit_b),
        .unit_result_i      (unit_result),
        .unit_result_valid_i(unit_result_valid),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_id_o           (rsp_id),
        .rsp_data_o         (rsp_data),
        .rsp_error_o        (rsp_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] rr_pick(input int ptr, input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[(ptr + i) % 4]) return 4'(1 << ((ptr + i) % 4));
        end
        return 4'b0000;
    endfunction

    // Behavioural combine unit: answers {a,b} unit_lat cycles after the strobe (0 = never).
    always @(negedge clk) begin
        unit_result_valid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (stray_req != stray_done) begin
                unit_result_valid = 1'b1;
                unit_result       = 16'hDEAD;
                stray_done        = stray_req;
            end else if (pend) begin
                if (pend_cnt == 1) begin
                    unit_result_valid = 1'b1;
                    unit_result       = pend_data;
                    pend              = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (unit_a_valid && unit_lat != 0) begin
                pend      = 1'b1;
                pend_cnt  = unit_lat;
                pend_data = {unit_a, unit_b};
            end
        end
    end

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        bit         exp_stb;
        int         idx;
        exp_t       e;
        if (reset) begin
            sb_q.delete();
            m_busy       = 1'b0;
            m_ptr        = 0;
            in_rsp       = 1'b0;
            cur_ok       = 1'b0;
            last_acc_cyc = -10;
        end else begin
            exp_rdy = m_busy ? 4'b0000 : rr_pick(m_ptr, req_valid);
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));

            exp_stb = (cyc == last_acc_cyc + 1);
            check_eq("strobe_a", 32'(unit_a_valid), 32'(exp_stb));
            check_eq("strobe_b", 32'(unit_b_valid), 32'(exp_stb));
            if (exp_stb) begin
                check_eq("unit_a", 32'(unit_a), 32'(last_a));
                check_eq("unit_b", 32'(unit_b), 32'(last_b));
            end

            if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    if (sb_q.size() == 0) begin
                        check_eq("rsp_unexpected", 32'(1), 32'(0));
                        cur_ok = 1'b0;
                    end else begin
                        cur    = sb_q.pop_front();
                        cur_ok = 1'b1;
                        check_eq("rsp_cycle", 32'(cyc), 32'(cur.cyc));
                    end
                end
                if (cur_ok) begin
                    check_eq("rsp_id", 32'(rsp_id), 32'(cur.id));
                    check_eq("rsp_data", 32'(rsp_data), 32'(cur.data));
                    check_eq("rsp_error", 32'(rsp_error), 32'(cur.err));
                end
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    m_busy = 1'b0;
                    if (cur_ok) m_ptr = (cur.id + 1) % 4;
                    hs_cyc = cyc;
                    n_rsp++;
                end
            end

            if (|(req_valid & req_ready)) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (req_valid[k] && req_ready[k]) idx = k;
                last_a       = req_a[8*idx +: 8];
                last_b       = req_b[8*idx +: 8];
                last_acc_cyc = cyc;
                e.id         = idx;
                if (unit_lat >= 1 && unit_lat <= TO) begin
                    e.data = {last_a, last_b};
                    e.err  = 1'b0;
                    e.cyc  = cyc + 2 + unit_lat;
                end else begin
                    e.data = 16'h0000;
                    e.err  = 1'b1;
                    e.cyc  = cyc + TO + 2;
                end
                sb_q.push_back(e);
                acc_id_q.push_back(idx);
                acc_cyc_q.push_back(cyc);
                m_busy = 1'b1;
                n_acc++;
            end
        end
    end

    task automatic wait_acc(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_acc >= target) begin
                #1;
                return;
            end
        end
        check_eq("accept_bound", 32'(n_acc), 32'(target));
        #1;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_rsp >= target) begin
                #1;
                return;
            end
        end
        check_eq("response_bound", 32'(n_rsp), 32'(target));
        #1;
    endtask

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        check_eq({tag, "_strobe"}, 32'({unit_a_valid, unit_b_valid}), 32'(0));
        check_eq({tag, "_unit_ops"}, 32'({unit_a, unit_b}), 32'(0));
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
        check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
        check_eq({tag, "_rsp_error"}, 32'(rsp_error), 32'(0));
    endtask

    initial begin
        int base;
        int t;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 req_valid = 4'hF;
        @(negedge clk);
        #2 check_reset_outputs("reset");
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Fairness: all four requesters held valid.
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) set_op(i, 8'(8'h10 + i), 8'(8'h80 + i));
        base      = n_acc;
        req_valid = 4'hF;
        wait_acc(base + 5, 100);
        req_valid = '0;
        wait_rsp(n_acc, 100);
        for (int k = 0; k < 5; k++) begin
            check_eq("fair_order", 32'(acc_id_q[base + k]), 32'(k % 4));
            if (k > 0) check_eq("fair_period", 32'(acc_cyc_q[base + k] - acc_cyc_q[base + k - 1]), 32'(6));
        end

        // Single request from requester 2.
        set_op(2, 8'hA5, 8'h3C);
        t         = n_acc;
        req_valid = 4'b0100;
        wait_acc(t + 1, 20);
        req_valid = '0;
        check_eq("single_id", 32'(acc_id_q[$]), 32'(2));
        wait_rsp(n_acc, 30);

        // Backpressure: hold rsp_ready low while requester 3 waits.
        rsp_ready = 1'b0;
        set_op(1, 8'h11, 8'h22);
        set_op(3, 8'h33, 8'h44);
        t         = n_acc;
        req_valid = 4'b0010;
        wait_acc(t + 1, 20);
        req_valid = 4'b1000;
        for (int i = 0; i < 30 && !in_rsp; i++) @(posedge clk);
        check_eq("bp_rsp_seen", 32'(in_rsp), 32'(1));
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_acc(t + 2, 20);
        req_valid = '0;
        check_eq("bp_next_id", 32'(acc_id_q[$]), 32'(3));
        check_eq("bp_next_grant", 32'(acc_cyc_q[$]), 32'(hs_cyc + 1));
        wait_rsp(n_acc, 30);

        // Timeout: unit never answers, then a stray strobe while idle.
        unit_lat = 0;
        set_op(0, 8'h77, 8'h88);
        t         = n_acc;
        req_valid = 4'b0001;
        wait_acc(t + 1, 20);
        req_valid = '0;
        wait_rsp(n_acc, 40);
        stray_req++;
        repeat (3) @(posedge clk);
        #1;
        check_eq("stray_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("stray_rsp_data", 32'(rsp_data), 32'(0));
        check_eq("stray_rsp_error", 32'(rsp_error), 32'(1));

        // Result on the same cycle the counter reaches the timeout.
        unit_lat = TO;
        set_op(1, 8'h5A, 8'hC3);
        t         = n_acc;
        req_valid = 4'b0010;
        wait_acc(t + 1, 20);
        req_valid = '0;
        wait_rsp(n_acc, 40);

        // Reset while waiting for the unit; ptr must return to 0.
        unit_lat = 3;
        set_op(2, 8'h99, 8'h66);
        t         = n_acc;
        req_valid = 4'b0100;
        wait_acc(t + 1, 20);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        req_valid = 4'hF;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        base = n_rsp;
        wait_acc(t + 2, 20);
        req_valid = '0;
        check_eq("post_reset_id", 32'(acc_id_q[$]), 32'(0));
        wait_rsp(base + 1, 30);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/pair_unit_arbiter.md
# pair_unit_arbiter

Round-robin arbiter and sequencer that shares one 8-bit pair-combine unit among N_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake, issues it to the unit as a one-cycle dual-valid strobe, and waits for the unit's 16-bit result or a watchdog timeout. It then returns the result, tagged with the requester index, over a valid/ready response port. It sits between client blocks and the combine unit and guarantees the unit never receives a new pair while busy.

## Interface
- N_REQ, 4: number of requesters, 2..8; ID_W = clog2(N_REQ)
- TIMEOUT, 15: maximum WAIT cycles before abort, 4..255
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  8*N_REQ  operand A, requester i at bits [8i+7:8i]
- req_b  in  8*N_REQ  operand B, same packing
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- unit_a_valid, unit_b_valid  out  1 each  issue strobes, always driven identically
- unit_a, unit_b  out  8 each  operands to unit
- unit_result  in  16  unit result
- unit_result_valid  in  1  unit result strobe
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the served requester
- rsp_data  out  16  captured result, 0 on error
- rsp_error  out  1  response produced by timeout

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready is combinational. It is one-hot on the first requester with req_valid=1, searching from ptr upward modulo N_REQ. It is all-zero if there are no requests or if the state is not IDLE. On handshake:
  - latch winner index, req_a and req_b slices into op registers
  - go to ISSUE
- ISSUE: unit_a_valid=unit_b_valid=1 for exactly this cycle; unit_a/unit_b = latched operands. Clear the wait counter. Go to WAIT.
- WAIT: counter increments each cycle.
  - unit_result_valid=1: capture unit_result into rsp_data, rsp_error=0, go to RESP.
  - Otherwise, counter reaching TIMEOUT: rsp_data=0, rsp_error=1, go to RESP.
  - If a result arrives in the same cycle the counter hits TIMEOUT, the result wins.
- RESP: rsp_valid=1; rsp_id, rsp_data, rsp_error are held stable until rsp_valid & rsp_ready. On handshake:
  - ptr = (winner+1) mod N_REQ
  - go to IDLE
- unit_result_valid outside WAIT is ignored; it does not change any state.
- Operand/response registers hold their values outside their active states. unit_a/unit_b keep their last values while the strobes are low.
- Reset values: state IDLE, ptr 0, req_ready 0, unit_a_valid/unit_b_valid 0, unit_a/unit_b 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_error 0, counter 0.
- Reset mid-operation aborts any transaction with no response. The unit shares the same reset.

## Timing
- Request accepted in cycle T (IDLE).
- Strobes high in T+1 (ISSUE).
- With nominal unit latency, unit_result_valid rises in T+4 and rsp_valid rises in T+5.
- With rsp_ready=1, IDLE returns in T+6, so back-to-back service has a 6-cycle period.
- This gives the unit at least two idle cycles between result and next issue.
- Timeout path: rsp_valid rises TIMEOUT+2 cycles after T.
- No combinational path from rsp_ready or unit_result_valid to any output. Only req_ready depends combinationally on req_valid and state.
- A requester dropping req_valid before the handshake is legal; it is simply not granted.

## Test plan
- Single request: req 2, a=0xA5, b=0x3C.
  - req_ready[2] is high in the accept cycle.
  - Strobes carry 0xA5/0x3C one cycle later.
  - rsp_valid at T+5 with rsp_id=2, rsp_data=0xA53C, rsp_error=0.
- Fairness: all 4 requesters valid continuously, rsp_ready=1.
  - Grants in order 0,1,2,3,0.
  - Each response carries its own {a,b}.
  - Successive accepts are 6 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_* are stable throughout and req_ready is all-zero.
  - Release rsp_ready: the next grant occurs one cycle after the response handshake.
- Timeout: unit never asserts result, TIMEOUT=15.
  - rsp_valid with rsp_error=1, rsp_data=0x0000 at T+17.
  - A later stray unit_result_valid in IDLE is ignored.
- Reset in WAIT: assert reset at T+3.
  - All outputs reach reset values immediately, with no response.
  - After release, the next request is served normally, starting with ptr=0 priority.
- Simultaneous event: result strobe in the same cycle the counter reaches TIMEOUT -> rsp_error=0 with the captured data.
